// File: rtl/rans_stream_packer.sv
// Packs rANS encoder output symbols little-endian into wide stream words with keep/last.
// Optional feature: define RANS_PACK_COUNT_EN to append a per-packet symbol-count trailer word.
module rans_stream_packer #(
  parameter int IN_WIDTH    = 8,
  parameter int OUT_WIDTH   = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_WIDTH-1:0]             in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic [OUT_WIDTH/IN_WIDTH-1:0]   out_keep,
  output logic                            out_last
);

  localparam int N     = OUT_WIDTH / IN_WIDTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N - 1);

  generate
    if ((OUT_WIDTH % IN_WIDTH) != 0 || N < 2 || COUNT_WIDTH < 1) begin : g_bad_params
      $error("rans_stream_packer: OUT_WIDTH must be a multiple (>=2x) of IN_WIDTH, COUNT_WIDTH >= 1");
    end
  endgenerate

  logic [IDX_W-1:0]     idx_reg;
  logic [OUT_WIDTH-1:0] acc_reg;
  logic                 out_valid_reg;
  logic [OUT_WIDTH-1:0] out_data_reg;
  logic [N-1:0]         out_keep_reg;
  logic                 out_last_reg;

  logic [OUT_WIDTH-1:0] word_data;
  logic [N-1:0]         word_keep;
  logic                 out_free;
  logic                 accept;
  logic                 complete;

  // The completing word is the accumulator with the incoming symbol merged into lane idx.
  // Lanes above idx are still zero because the accumulator clears on every completion.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      localparam logic [IDX_W-1:0] LANE = IDX_W'(gi);
      assign word_data[gi*IN_WIDTH +: IN_WIDTH] =
        (idx_reg == LANE) ? in_data : acc_reg[gi*IN_WIDTH +: IN_WIDTH];
      assign word_keep[gi] = (LANE <= idx_reg);
    end
  endgenerate

  assign out_free = !out_valid_reg || out_ready;

`ifdef RANS_PACK_COUNT_EN
  typedef enum logic {FILL, TRAILER} state_t;

  state_t                 state_reg;
  logic                   trailer_loaded_reg;
  logic [COUNT_WIDTH-1:0] count_reg;
  logic [OUT_WIDTH-1:0]   trailer_data;

  generate
    if (COUNT_WIDTH >= OUT_WIDTH) begin : g_trail_trunc
      assign trailer_data = count_reg[OUT_WIDTH-1:0];
    end else begin : g_trail_zext
      assign trailer_data = {{(OUT_WIDTH-COUNT_WIDTH){1'b0}}, count_reg};
    end
  endgenerate

  assign in_ready = !rst && (state_reg == FILL) && out_free;
`else
  assign in_ready = !rst && out_free;
`endif

  assign accept   = in_valid && in_ready;
  assign complete = accept && (in_last || (idx_reg == LAST_LANE));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg       <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_keep_reg  <= '0;
      out_last_reg  <= 1'b0;
`ifdef RANS_PACK_COUNT_EN
      state_reg          <= FILL;
      trailer_loaded_reg <= 1'b0;
      count_reg          <= '0;
`endif
    end else begin
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end

`ifdef RANS_PACK_COUNT_EN
      // TRAILER holds the packet's final data word first, then the count word.
      if (state_reg == TRAILER && out_valid_reg && out_ready) begin
        if (!trailer_loaded_reg) begin
          out_valid_reg      <= 1'b1;
          out_data_reg       <= trailer_data;
          out_keep_reg       <= '1;
          out_last_reg       <= 1'b1;
          trailer_loaded_reg <= 1'b1;
        end else begin
          state_reg          <= FILL;
          trailer_loaded_reg <= 1'b0;
          count_reg          <= '0;
        end
      end
`endif

      if (accept) begin
`ifdef RANS_PACK_COUNT_EN
        count_reg <= count_reg + COUNT_WIDTH'(1);
`endif
        if (complete) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= word_data;
          out_keep_reg  <= word_keep;
`ifdef RANS_PACK_COUNT_EN
          out_last_reg  <= 1'b0;
          if (in_last) begin
            state_reg <= TRAILER;
          end
`else
          out_last_reg  <= in_last;
`endif
          acc_reg <= '0;
          idx_reg <= '0;
        end else begin
          acc_reg[idx_reg*IN_WIDTH +: IN_WIDTH] <= in_data;
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_keep  = out_keep_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_rans_stream_packer.sv
// Self-checking bench for rans_stream_packer: packet-level chunking model plus literal word checks.
module tb_rans_stream_packer;

  localparam int IW = 8;
  localparam int OW = 32;
  localparam int NL = OW / IW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic [NL-1:0] out_keep;
  logic          out_last;

  rans_stream_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .COUNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OW-1:0] d;
    logic [NL-1:0] k;
    logic          l;
  } word_t;

  int    check_count = 0;
  int    pass_count  = 0;
  int    cyc = 0;
  word_t exp_q[$];
  word_t rx_q[$];
  logic [IW-1:0] pk[$];
  bit    trailer_owed = 0;
  bit    lat_pending = 0;
  bit    stall_prev = 0;
  word_t stall_word;
  int unsigned pkt_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    check_count++;
    if (act === req) pass_count++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  always @(posedge clk) cyc++;

  // Model: symbols accepted are chunked into NL-lane words per packet; a word closes on a full
  // chunk or on the packet's last symbol.
  always @(negedge clk) begin
    word_t w, t;
    if (rst) begin
      check("in_ready_during_rst", 64'(in_ready), 64'd0);
      exp_q.delete(); pk.delete();
      trailer_owed = 0; lat_pending = 0; stall_prev = 0; pkt_cnt = 0;
    end else begin
      if (lat_pending) check("latency_out_valid", 64'(out_valid), 64'd1);
      lat_pending = 0;
      if (stall_prev)
        check("stable_under_stall", 64'({out_valid, out_data, out_keep, out_last}),
              64'({1'b1, stall_word}));
      check("in_ready_rule", 64'(in_ready), 64'(!trailer_owed && (!out_valid || out_ready)));
      if (out_valid && out_ready) begin
        w = '{d: out_data, k: out_keep, l: out_last};
        rx_q.push_back(w);
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(w), 64'd0);
        end else begin
          t = exp_q.pop_front();
          check("word_vs_model", 64'(w), 64'(t));
          $display("word data=%08h keep=%b last=%0d", w.d, w.k, w.l);
          if (t.l) trailer_owed = 0;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_word = '{d: out_data, k: out_keep, l: out_last};
      if (in_valid && in_ready) begin
        pk.push_back(in_data);
        pkt_cnt++;
        if (pk.size() == NL || in_last) begin
          w.d = '0;
          foreach (pk[i]) w.d[i*IW +: IW] = pk[i];
          w.k = NL'((1 << pk.size()) - 1);
`ifdef RANS_PACK_COUNT_EN
          w.l = 1'b0;
          exp_q.push_back(w);
          if (in_last) begin
            t = '{d: OW'(pkt_cnt), k: '1, l: 1'b1};
            exp_q.push_back(t);
            trailer_owed = 1;
          end
`else
          w.l = in_last;
          exp_q.push_back(w);
`endif
          if (in_last) pkt_cnt = 0;
          pk.delete();
          lat_pending = 1;
        end
      end
    end
  end

  bit tog_en = 0;
  int tcyc = 0;
  always @(posedge clk) begin
    #1;
    if (tog_en) begin
      out_ready = (tcyc % 4 == 0) || (tcyc % 4 == 3);
      tcyc++;
    end
  end

  task automatic send(input logic [IW-1:0] d, input logic l);
    bit got;
    got = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk); got = in_ready;
      @(posedge clk); #1;
    end
    if (!got) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0) && n < 300) begin
      @(posedge clk); #2; n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic expect_word(input int i, input logic [OW-1:0] d, input logic [NL-1:0] k,
                             input logic l);
    if (i >= rx_q.size()) check("literal_word_missing", 64'(rx_q.size()), 64'(i + 1));
    else check("literal_word", 64'(rx_q[i]), 64'(word_t'{d: d, k: k, l: l}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", pass_count, check_count);
    $fatal(1);
  end

  initial begin
    int base, t0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_keep",  64'(out_keep),  64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);

    // 1: two full words, sustained throughput
    base = rx_q.size(); t0 = cyc;
    for (int i = 1; i <= 8; i++) send(IW'(i), i == 8);
    check("throughput_8_cycles", 64'(cyc - t0), 64'd8);
    drain();
`ifdef RANS_PACK_COUNT_EN
    expect_word(base,     32'h04030201, 4'hF, 1'b0);
    expect_word(base + 1, 32'h08070605, 4'hF, 1'b0);
    expect_word(base + 2, 32'h00000008, 4'hF, 1'b1);
`else
    expect_word(base,     32'h04030201, 4'hF, 1'b0);
    expect_word(base + 1, 32'h08070605, 4'hF, 1'b1);
`endif

    // 2: partial word and single-symbol packet
    base = rx_q.size();
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
    send(8'h5A, 1);
    drain();
`ifdef RANS_PACK_COUNT_EN
    expect_word(base,     32'h00CCBBAA, 4'b0111, 1'b0);
    expect_word(base + 1, 32'h00000003, 4'hF,    1'b1);
    expect_word(base + 2, 32'h0000005A, 4'b0001, 1'b0);
    expect_word(base + 3, 32'h00000001, 4'hF,    1'b1);
`else
    expect_word(base,     32'h00CCBBAA, 4'b0111, 1'b1);
    expect_word(base + 1, 32'h0000005A, 4'b0001, 1'b1);
`endif

    // 3: 12 symbols under a 1,0,0,1 ready pattern
    base = rx_q.size();
    tog_en = 1;
    for (int i = 0; i < 12; i++) send(IW'(8'h30 + i), i == 11);
    drain();
    tog_en = 0; out_ready = 1'b1;
    check("stall_rx_words", 64'(rx_q.size() - base), 64'(OW == 32 ? 3 : 0)
`ifdef RANS_PACK_COUNT_EN
          + 64'd1
`endif
    );

    // 4a: reset with a completed word pending at a stalled sink
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(IW'(8'h91 + i), 0);
    pulse_rst();
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data",  64'(out_data),  64'd0);
    out_ready = 1'b1;

    // 4b: reset after two symbols of a packet, then a clean packet
    base = rx_q.size();
    send(8'hA1, 0); send(8'hA2, 0);
    pulse_rst();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 1);
    drain();
`ifdef RANS_PACK_COUNT_EN
    expect_word(base,     32'h44332211, 4'hF, 1'b0);
    expect_word(base + 1, 32'h00000004, 4'hF, 1'b1);
`else
    expect_word(base,     32'h44332211, 4'hF, 1'b1);
`endif

`ifdef RANS_PACK_COUNT_EN
    // 5: six-symbol packet with trailer
    base = rx_q.size();
    for (int i = 1; i <= 6; i++) send(IW'(i), i == 6);
    drain();
    expect_word(base,     32'h04030201, 4'hF,    1'b0);
    expect_word(base + 1, 32'h00000605, 4'b0011, 1'b0);
    expect_word(base + 2, 32'h00000006, 4'hF,    1'b1);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
